// File: rtl/i2c_opl3_reg_bridge.sv
// Decodes I2C write transactions (ctrl, addr, data...) into OPL3 register writes, buffered in a FWFT FIFO.
// Latency 1 cycle from data byte to opl_wr_valid; a full FIFO NACKs the byte, drops it and ignores the rest.
module i2c_opl3_reg_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_10MHz,
    input  logic                 areset_n,
    input  logic                 rx_start,
    input  logic                 rx_stop,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_ack,
    output logic                 opl_wr_valid,
    output logic [8:0]           opl_wr_addr,
    output logic [7:0]           opl_wr_data,
    input  logic                 opl_wr_ready,
    input  logic                 ovf_clr,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] wr_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CTRL, ADDR, DATA, IGNORE} state_t;

    state_t                r_state;
    logic                  r_bank;
    logic                  r_autoinc;
    logic [8:0]            r_cur_addr;
    logic [16:0]           r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [16:0]           r_head;
    logic                  r_overflow;
    logic [CNT_WIDTH-1:0]  r_wr_count;

    logic                  w_full;
    logic                  w_byte;
    logic                  w_push;
    logic                  w_ovf;
    logic                  w_pop;
    logic [PW-1:0]         w_rptr_nxt;
    logic [CW-1:0]         w_count_nxt;
    logic [16:0]           w_push_dat;

    // Start/stop take priority, so a byte arriving with either is never consumed.
    assign w_full      = (r_count == FULL_CNT);
    assign w_byte      = rx_valid & ~rx_start & ~rx_stop;
    assign w_push      = w_byte & (r_state == DATA) & ~w_full;
    assign w_ovf       = w_byte & (r_state == DATA) & w_full;
    assign w_pop       = opl_wr_valid & opl_wr_ready;
    assign w_rptr_nxt  = r_rptr + PW'(w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_push_dat  = {r_cur_addr, rx_data};

    assign rx_ack       = (r_state == CTRL) || (r_state == ADDR) || ((r_state == DATA) && !w_full);
    assign opl_wr_valid = (r_count != '0);
    assign opl_wr_addr  = r_head[16:8];
    assign opl_wr_data  = r_head[7:0];
    assign overflow     = r_overflow;
    assign wr_count     = r_wr_count;

    always_ff @(posedge clk_10MHz or negedge areset_n) begin
        if (!areset_n) begin
            r_state    <= IDLE;
            r_bank     <= 1'b0;
            r_autoinc  <= 1'b0;
            r_cur_addr <= '0;
        end else if (rx_start) begin
            r_state <= CTRL;
        end else if (rx_stop) begin
            r_state <= IDLE;
        end else if (rx_valid) begin
            case (r_state)
                CTRL: begin
                    r_bank    <= rx_data[0];
                    r_autoinc <= rx_data[7];
                    r_state   <= ADDR;
                end
                ADDR: begin
                    r_cur_addr <= {r_bank, rx_data};
                    r_state    <= DATA;
                end
                DATA: begin
                    if (w_full) begin
                        r_state <= IGNORE;
                    end else if (r_autoinc) begin
                        r_cur_addr <= r_cur_addr + 9'd1;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    always_ff @(posedge clk_10MHz) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_dat;
        end
    end

    // The head is registered so it holds the last popped entry once the FIFO drains.
    always_ff @(posedge clk_10MHz or negedge areset_n) begin
        if (!areset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_push);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            if (w_count_nxt != '0) begin
                if (w_push && (r_wptr == w_rptr_nxt)) begin
                    r_head <= w_push_dat;
                end else begin
                    r_head <= r_mem[w_rptr_nxt];
                end
            end
        end
    end

    always_ff @(posedge clk_10MHz or negedge areset_n) begin
        if (!areset_n) begin
            r_overflow <= 1'b0;
            r_wr_count <= '0;
        end else begin
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_pop) begin
                r_wr_count <= r_wr_count + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_i2c_opl3_reg_bridge.sv
// Directed bench for i2c_opl3_reg_bridge: hand-computed register writes checked against captured pops.
module tb_i2c_opl3_reg_bridge;
    logic        clk_10MHz = 1'b0;
    logic        areset_n = 1'b0;
    logic        rx_start = 1'b0;
    logic        rx_stop = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ack;
    logic        opl_wr_valid;
    logic [8:0]  opl_wr_addr;
    logic [7:0]  opl_wr_data;
    logic        opl_wr_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        overflow;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_fail = 0;
    logic [16:0] pops[$];

    i2c_opl3_reg_bridge #(.FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk_10MHz(clk_10MHz), .areset_n(areset_n),
        .rx_start(rx_start), .rx_stop(rx_stop), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ack(rx_ack), .opl_wr_valid(opl_wr_valid), .opl_wr_addr(opl_wr_addr),
        .opl_wr_data(opl_wr_data), .opl_wr_ready(opl_wr_ready),
        .ovf_clr(ovf_clr), .overflow(overflow), .wr_count(wr_count)
    );

    always #50 clk_10MHz = ~clk_10MHz;

    // Records every accepted write; inputs change on negedge, so negedge+1 sees what the next posedge uses.
    initial begin
        forever begin
            @(negedge clk_10MHz);
            #1;
            if (areset_n && opl_wr_valid && opl_wr_ready) pops.push_back({opl_wr_addr, opl_wr_data});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_10MHz);
    endtask

    task automatic do_start();
        @(negedge clk_10MHz); rx_start = 1'b1;
        @(negedge clk_10MHz); rx_start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk_10MHz); rx_stop = 1'b1;
        @(negedge clk_10MHz); rx_stop = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, output logic ack);
        @(negedge clk_10MHz);
        rx_valid = 1'b1; rx_data = b;
        #1 ack = rx_ack;
        @(negedge clk_10MHz);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_checks += 4;
        if (opl_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", opl_wr_valid); end
        if ({opl_wr_addr, opl_wr_data} !== 17'h0) begin n_fail++; $display("FAIL reset_head got %h want 0", {opl_wr_addr, opl_wr_data}); end
        if ({overflow, rx_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_ovf_ack got %b want 00", {overflow, rx_ack}); end
        if (wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
    endtask

    task automatic test_autoinc();
        logic [7:0] bytes [4] = '{8'h80, 8'hB0, 8'h11, 8'h22};
        logic [16:0] exp [2] = '{{9'h0B0, 8'h11}, {9'h0B1, 8'h22}};
        logic a;
        pops.delete();
        opl_wr_ready = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(bytes[i], a);
            n_checks++;
            if (a !== 1'b1) begin n_fail++; $display("FAIL autoinc_ack%0d got %b want 1", i, a); end
        end
        do_stop();
        cycles(4);
        n_checks++;
        if (pops.size() != 2) begin n_fail++; $display("FAIL autoinc_npops got %0d want 2", pops.size()); end
        for (int i = 0; i < 2 && i < pops.size(); i++) begin
            n_checks++;
            if (pops[i] !== exp[i]) begin n_fail++; $display("FAIL autoinc_wr%0d got %h want %h", i, pops[i], exp[i]); end
        end
        n_checks++;
        if (wr_count !== 16'd2) begin n_fail++; $display("FAIL autoinc_wr_count got %0d want 2", wr_count); end
    endtask

    task automatic test_bank_wrap();
        logic [7:0] ctrl [2] = '{8'h01, 8'h81};
        logic [16:0] exp [4] = '{{9'h1FF, 8'hAA}, {9'h1FF, 8'hBB}, {9'h1FF, 8'hAA}, {9'h000, 8'hBB}};
        logic a;
        pops.delete();
        for (int t = 0; t < 2; t++) begin
            do_start();
            send(ctrl[t], a); send(8'hFF, a); send(8'hAA, a); send(8'hBB, a);
            do_stop();
        end
        cycles(4);
        n_checks++;
        if (pops.size() != 4) begin n_fail++; $display("FAIL bank_npops got %0d want 4", pops.size()); end
        for (int i = 0; i < 4 && i < pops.size(); i++) begin
            n_checks++;
            if (pops[i] !== exp[i]) begin n_fail++; $display("FAIL bank_wr%0d got %h want %h", i, pops[i], exp[i]); end
        end
        n_checks++;
        if (wr_count !== 16'd6) begin n_fail++; $display("FAIL bank_wr_count got %0d want 6", wr_count); end
    endtask

    task automatic test_overflow();
        logic exp_ack [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic a;
        pops.delete();
        opl_wr_ready = 1'b0;
        do_start();
        send(8'h00, a); send(8'h10, a);
        for (int i = 0; i < 6; i++) begin
            send(8'hD0 + 8'(i), a);
            n_checks++;
            if (a !== exp_ack[i]) begin n_fail++; $display("FAIL ovf_ack%0d got %b want %b", i, a, exp_ack[i]); end
            if (i == 4) begin
                n_checks++;
                if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
            end
        end
        do_stop();
        n_checks++;
        if (opl_wr_valid !== 1'b1 || pops.size() != 0) begin
            n_fail++; $display("FAIL ovf_stalled got valid=%b pops=%0d want 1/0", opl_wr_valid, pops.size());
        end
        @(negedge clk_10MHz); opl_wr_ready = 1'b1;
        cycles(8);
        n_checks++;
        if (pops.size() != 4) begin n_fail++; $display("FAIL ovf_npops got %0d want 4", pops.size()); end
        for (int i = 0; i < 4 && i < pops.size(); i++) begin
            n_checks++;
            if (pops[i] !== {9'h010, 8'hD0 + 8'(i)}) begin
                n_fail++; $display("FAIL ovf_wr%0d got %h want %h", i, pops[i], {9'h010, 8'hD0 + 8'(i)});
            end
        end
        n_checks++;
        if (wr_count !== 16'd10) begin n_fail++; $display("FAIL ovf_wr_count got %0d want 10", wr_count); end
        @(negedge clk_10MHz); ovf_clr = 1'b1;
        @(negedge clk_10MHz); ovf_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", overflow); end
    endtask

    task automatic test_restart();
        logic [16:0] exp [3] = '{{9'h040, 8'h01}, {9'h041, 8'h02}, {9'h020, 8'h33}};
        logic a;
        pops.delete();
        opl_wr_ready = 1'b0;
        do_start();
        send(8'h80, a); send(8'h40, a); send(8'h01, a); send(8'h02, a);
        do_start();
        send(8'h00, a); send(8'h20, a); send(8'h33, a);
        do_stop();
        @(negedge clk_10MHz); opl_wr_ready = 1'b1;
        cycles(6);
        n_checks++;
        if (pops.size() != 3) begin n_fail++; $display("FAIL restart_npops got %0d want 3", pops.size()); end
        for (int i = 0; i < 3 && i < pops.size(); i++) begin
            n_checks++;
            if (pops[i] !== exp[i]) begin n_fail++; $display("FAIL restart_wr%0d got %h want %h", i, pops[i], exp[i]); end
        end
    endtask

    task automatic test_collisions();
        logic a;
        pops.delete();
        opl_wr_ready = 1'b1;
        @(negedge clk_10MHz); rx_start = 1'b1; rx_valid = 1'b1; rx_data = 8'h81;
        @(negedge clk_10MHz); rx_start = 1'b0; rx_valid = 1'b0;
        n_checks++;
        if (rx_ack !== 1'b1) begin n_fail++; $display("FAIL coll_start_ctrl got ack %b want 1", rx_ack); end
        send(8'h00, a); send(8'h50, a); send(8'h44, a);
        @(negedge clk_10MHz); rx_stop = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
        @(negedge clk_10MHz); rx_stop = 1'b0; rx_valid = 1'b0;
        n_checks++;
        if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL coll_stop_idle got ack %b want 0", rx_ack); end
        send(8'h66, a);
        n_checks++;
        if (a !== 1'b0) begin n_fail++; $display("FAIL coll_idle_byte_ack got %b want 0", a); end
        cycles(3);
        n_checks++;
        if (pops.size() != 1 || (pops.size() == 1 && pops[0] !== {9'h050, 8'h44})) begin
            n_fail++; $display("FAIL coll_writes got n=%0d first=%h want n=1 first=%h",
                               pops.size(), (pops.size() > 0) ? pops[0] : 17'h0, {9'h050, 8'h44});
        end
        n_checks++;
        if (wr_count !== 16'd14) begin n_fail++; $display("FAIL coll_wr_count got %0d want 14", wr_count); end
    endtask

    task automatic test_async_reset();
        logic a;
        opl_wr_ready = 1'b0;
        do_start();
        send(8'h00, a); send(8'h60, a); send(8'hA1, a); send(8'hA2, a); send(8'hA3, a);
        n_checks++;
        if (opl_wr_valid !== 1'b1 || rx_ack !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre got valid=%b ack=%b want 1/1", opl_wr_valid, rx_ack);
        end
        #20 areset_n = 1'b0;
        #1;
        n_checks += 2;
        if ({opl_wr_valid, overflow, rx_ack} !== 3'b000) begin
            n_fail++; $display("FAIL arst_flags got %b want 000", {opl_wr_valid, overflow, rx_ack});
        end
        if (wr_count !== 16'd0) begin n_fail++; $display("FAIL arst_wr_count got %0d want 0", wr_count); end
        @(negedge clk_10MHz); areset_n = 1'b1;
        pops.delete();
        opl_wr_ready = 1'b1;
        send(8'h00, a);
        n_checks++;
        if (a !== 1'b0) begin n_fail++; $display("FAIL arst_idle_ack got %b want 0", a); end
        send(8'h70, a); send(8'hB1, a);
        cycles(2);
        n_checks++;
        if (pops.size() != 0) begin n_fail++; $display("FAIL arst_idle_pops got %0d want 0", pops.size()); end
        do_start();
        send(8'h00, a); send(8'h70, a); send(8'hB2, a);
        cycles(3);
        n_checks++;
        if (pops.size() != 1 || (pops.size() == 1 && pops[0] !== {9'h070, 8'hB2})) begin
            n_fail++; $display("FAIL arst_after got n=%0d want single %h", pops.size(), {9'h070, 8'hB2});
        end
        n_checks++;
        if (wr_count !== 16'd1) begin n_fail++; $display("FAIL arst_after_count got %0d want 1", wr_count); end
    endtask

    initial begin
        #120;
        test_reset();
        @(negedge clk_10MHz); areset_n = 1'b1;
        test_autoinc();
        test_bank_wrap();
        test_overflow();
        test_restart();
        test_collisions();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
